capacitive_sensor_scanner: RTL and testbench
============================================

// Module: capacitive_sensor_scanner
// PURPOSE
//  Input-side counterpart to the LED command path of the whack-a-mole skeleton.
//  It charges the 9 capacitive pads through capacitive_sensors_out and times each pad's rise on capacitive_sensors_in.
//  It then thresholds and debounces the rise times, and presents touch state and sticky hit flags to the processor.
//  The processor reads hit_flags and clears them with a hit_clear mask.
// PARAMETERS
//  CNT_W            10    width of per-channel rise-time counters
//  MAX_COUNT        1023  charge-phase length in cycles; a count saturates here
//  THRESHOLD        200   rise count >= THRESHOLD means pad touched (raw)
//  DISCHARGE_CYCLES 256   cycles capacitive_sensors_out is held low after charge
//  SCAN_INTERVAL    1000  idle cycles between scans
//  DEBOUNCE         3     consecutive agreeing scans needed to change touch_state
// PORTS
//  clock                   in   1  system clock
//  reset                   in   1  asynchronous, active-high reset
//  enable                  in   1  1 = scanning runs; 0 = abort and stay idle
//  capacitive_sensors_in   in   9  raw asynchronous pad inputs
//  capacitive_sensors_out  out  1  shared charge drive to all pads
//  touch_state             out  9  debounced level: 1 = pad currently touched
//  hit_flags               out  9  sticky; set on a 0->1 edge of touch_state
//  hit_clear               in   9  per-bit clear of hit_flags (1-cycle strobe)
//  scan_done               out  1  1-cycle pulse after each completed EVALUATE
// BEHAVIOUR
//  Reset values: capacitive_sensors_out=0, touch_state=0, hit_flags=0, scan_done=0.
//   Counters, debounce counters and the 2-flop sync chains are cleared; FSM=IDLE.
//  Sync: each input passes a 2-flop synchronizer. All timing refers to synced values (2-cycle lag).
//  FSM IDLE -> CHARGE -> DISCHARGE -> EVAL -> IDLE.
//   IDLE: out=0. Interval counter counts to SCAN_INTERVAL-1, then goes to CHARGE.
//    With enable=0 the counter holds at 0 and the FSM stays in IDLE.
//   CHARGE: out=1 for exactly MAX_COUNT cycles. Each channel's count[i] increments every cycle
//    until synced in[i] is first seen 1, then freezes. count[i] never exceeds MAX_COUNT.
//    A channel never seen high ends at MAX_COUNT.
//   DISCHARGE: out=0 for DISCHARGE_CYCLES cycles; counts are held.
//   EVAL, 1 cycle:
//    - raw[i] = (count[i] >= THRESHOLD).
//    - If raw[i] != touch_state[i], deb[i]++; else deb[i]=0.
//    - If deb[i] reaches DEBOUNCE, touch_state[i] flips and deb[i]=0.
//    - scan_done=1 this cycle. Counts are cleared for the next scan.
//  touch_state, hit_flags and scan_done update together at the EVAL clock edge.
//  hit_flags[i] sets in the cycle touch_state[i] goes 0->1. A 1->0 transition does not clear it.
//   hit_clear[i] clears it on the next edge.
//   If set and clear coincide on the same bit, set wins and the flag stays 1.
//   Clearing a bit that is already 0 has no effect. Other bits are unaffected.
//  enable falling mid-scan (CHARGE/DISCHARGE): next cycle FSM=IDLE and out=0.
//   Partial counts are discarded. touch_state, deb and hit_flags are held; no scan_done.
//  enable rising: the first CHARGE starts SCAN_INTERVAL cycles later.
//  reset mid-scan: out drops to 0 asynchronously and all state returns to reset values.
//  Counter widths: CNT_W must hold MAX_COUNT. The interval and discharge counters are sized
//   with $clog2 of their parameter. No counter wraps; all saturate or reload.
//  Scan period = SCAN_INTERVAL + MAX_COUNT + DISCHARGE_CYCLES + 1 cycles
//   (2280 with default parameters).
// TESTING (use MAX_COUNT=63, THRESHOLD=20, DISCHARGE_CYCLES=8, SCAN_INTERVAL=10, DEBOUNCE=3)
//  1. Reset, enable=1, pads follow out with a 5-cycle delay:
//     -> 1st CHARGE begins 10 cycles after reset release, out high for 63 cycles.
//     -> scan_done every 82 cycles; touch_state stays 0 and hit_flags stays 0.
//  2. Pad 4 delay 40 cycles, others 5:
//     -> touch_state[4] rises at the 3rd EVAL, with hit_flags[4]=1 the same cycle.
//     -> All other bits stay 0.
//  3. Pad 0 never rises:
//     -> count saturates at 63, raw=1, touch_state[0]=1 after 3 scans.
//  4. Pad 2 alternates touched/untouched every scan:
//     -> touch_state[2] never changes; hit_flags[2] stays 0.
//  5. hit_flags=9'h010, hit_clear=9'h010 asserted on the EVAL edge that sets bit 4:
//     -> hit_flags[4] stays 1.
//     -> A later hit_clear=9'h010 gives hit_flags=0 next cycle.
//  6. Drop enable at cycle 30 of CHARGE, or reset mid-DISCHARGE:
//     -> out=0 next cycle (immediately for reset) and no scan_done.
//     -> Touch state held on the enable drop; all outputs 0 on reset.

Source files
------------

// File: rtl/capacitive_sensor_scanner.sv
// Capacitive pad scanner: charges all pads, times each pad's rise, then thresholds and
// debounces the rise times into a touch level plus sticky hit flags for the processor.
module capacitive_sensor_scanner #(
    parameter int CNT_W            = 10,
    parameter int MAX_COUNT        = 1023,
    parameter int THRESHOLD        = 200,
    parameter int DISCHARGE_CYCLES = 256,
    parameter int SCAN_INTERVAL    = 1000,
    parameter int DEBOUNCE         = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [8:0] capacitive_sensors_in,
    output logic       capacitive_sensors_out,
    output logic [8:0] touch_state,
    output logic [8:0] hit_flags,
    input  logic [8:0] hit_clear,
    output logic       scan_done
);

    localparam int N     = 9;
    localparam int INT_W = (SCAN_INTERVAL > 1) ? $clog2(SCAN_INTERVAL) : 1;
    localparam int DIS_W = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam int DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;

    localparam logic [INT_W-1:0] INT_LAST = INT_W'(SCAN_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CHG_LAST = CNT_W'(MAX_COUNT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_COUNT);
    localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESHOLD);
    localparam logic [DIS_W-1:0] DIS_LAST = DIS_W'(DISCHARGE_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CHARGE    = 2'd1,
        DISCHARGE = 2'd2,
        EVAL      = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [N-1:0]               sync1_q, sync2_q;
    logic [INT_W-1:0]           int_q, int_d;
    logic [CNT_W-1:0]           chg_q, chg_d;
    logic [DIS_W-1:0]           dis_q, dis_d;
    logic [N-1:0][CNT_W-1:0]    count_q, count_d;
    logic [N-1:0]               seen_q, seen_d;
    logic [N-1:0][DEB_W-1:0]    deb_q, deb_d;
    logic [N-1:0]               touch_q, touch_d;
    logic [N-1:0]               hit_q, hit_d;
    logic [N-1:0]               raw_s;
    logic                       out_q, out_d;
    logic                       done_q, done_d;
    logic                       eval_s;

    // Two-flop synchronizer on the asynchronous pad inputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= {N{1'b0}};
            sync2_q <= {N{1'b0}};
        end else begin
            sync1_q <= capacitive_sensors_in;
            sync2_q <= sync1_q;
        end
    end

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; dropping enable aborts any charge/discharge phase
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enable && (int_q == INT_LAST)) state_d = CHARGE;
                else                               state_d = IDLE;
            end
            CHARGE: begin
                if (!enable)                 state_d = IDLE;
                else if (chg_q == CHG_LAST)  state_d = DISCHARGE;
                else                         state_d = CHARGE;
            end
            DISCHARGE: begin
                if (!enable)                 state_d = IDLE;
                else if (dis_q == DIS_LAST)  state_d = EVAL;
                else                         state_d = DISCHARGE;
            end
            EVAL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, decoded from the next state so the registered copies track the FSM
    always_comb begin
        out_d  = 1'b0;
        done_d = 1'b0;
        case (state_d)
            CHARGE:    out_d  = 1'b1;
            EVAL:      done_d = 1'b1;
            IDLE:      out_d  = 1'b0;
            DISCHARGE: out_d  = 1'b0;
            default:   out_d  = 1'b0;
        endcase
    end

    // Phase counters: interval, charge length and discharge length
    always_comb begin
        int_d = {INT_W{1'b0}};
        chg_d = {CNT_W{1'b0}};
        dis_d = {DIS_W{1'b0}};
        if ((state_q == IDLE) && (state_d == IDLE) && enable) int_d = int_q + INT_W'(1);
        else                                                  int_d = {INT_W{1'b0}};
        if ((state_q == CHARGE) && (state_d == CHARGE))       chg_d = chg_q + CNT_W'(1);
        else                                                  chg_d = {CNT_W{1'b0}};
        if ((state_q == DISCHARGE) && (state_d == DISCHARGE)) dis_d = dis_q + DIS_W'(1);
        else                                                  dis_d = {DIS_W{1'b0}};
    end

    // Per-channel rise-time counters: freeze on the first synced high, saturate at MAX_COUNT
    always_comb begin
        count_d = count_q;
        seen_d  = seen_q;
        for (int i = 0; i < N; i++) begin
            if (state_q == CHARGE) begin
                seen_d[i] = seen_q[i] | sync2_q[i];
                if (!seen_q[i] && !sync2_q[i] && (count_q[i] != CNT_MAX)) begin
                    count_d[i] = count_q[i] + CNT_W'(1);
                end else begin
                    count_d[i] = count_q[i];
                end
            end else if (state_q == DISCHARGE) begin
                seen_d[i]  = 1'b0;
                count_d[i] = count_q[i];
            end else begin
                seen_d[i]  = 1'b0;
                count_d[i] = {CNT_W{1'b0}};
            end
        end
    end

    // Threshold and debounce, evaluated on the edge that enters EVAL
    always_comb begin
        eval_s  = (state_q == DISCHARGE) && (state_d == EVAL);
        touch_d = touch_q;
        deb_d   = deb_q;
        raw_s   = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            raw_s[i] = (count_q[i] >= CNT_THR);
            if (eval_s) begin
                if (raw_s[i] != touch_q[i]) begin
                    if (deb_q[i] == DEB_LAST) begin
                        touch_d[i] = ~touch_q[i];
                        deb_d[i]   = {DEB_W{1'b0}};
                    end else begin
                        deb_d[i]   = deb_q[i] + DEB_W'(1);
                    end
                end else begin
                    deb_d[i] = {DEB_W{1'b0}};
                end
            end else begin
                deb_d[i] = deb_q[i];
            end
        end
        // a rising touch edge beats a simultaneous clear
        hit_d = (hit_q & ~hit_clear) | (touch_d & ~touch_q);
    end

    // Datapath and output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            int_q   <= {INT_W{1'b0}};
            chg_q   <= {CNT_W{1'b0}};
            dis_q   <= {DIS_W{1'b0}};
            count_q <= '{default: {CNT_W{1'b0}}};
            seen_q  <= {N{1'b0}};
            deb_q   <= '{default: {DEB_W{1'b0}}};
            touch_q <= {N{1'b0}};
            hit_q   <= {N{1'b0}};
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            int_q   <= int_d;
            chg_q   <= chg_d;
            dis_q   <= dis_d;
            count_q <= count_d;
            seen_q  <= seen_d;
            deb_q   <= deb_d;
            touch_q <= touch_d;
            hit_q   <= hit_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign capacitive_sensors_out = out_q;
    assign touch_state            = touch_q;
    assign hit_flags              = hit_q;
    assign scan_done              = done_q;

endmodule

// File: tb/tb_capacitive_sensor_scanner.sv
// Self-checking bench for capacitive_sensor_scanner: directed scan table, multi-cycle corner
// sequences, and randomized pad timing checked against a scan-level reference model.
module tb_capacitive_sensor_scanner;

    localparam int MAXC = 63;
    localparam int THR  = 20;
    localparam int DISC = 8;
    localparam int SINT = 10;
    localparam int DEB  = 3;
    localparam int SCAN = SINT + MAXC + DISC + 1;
    localparam int NEVER = 1000;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic [8:0] cs_in;
    logic       cs_out;
    logic [8:0] ts;
    logic [8:0] hit;
    logic [8:0] clr;
    logic       done;

    capacitive_sensor_scanner #(
        .CNT_W(6), .MAX_COUNT(MAXC), .THRESHOLD(THR),
        .DISCHARGE_CYCLES(DISC), .SCAN_INTERVAL(SINT), .DEBOUNCE(DEB)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .enable                (enable),
        .capacitive_sensors_in (cs_in),
        .capacitive_sensors_out(cs_out),
        .touch_state           (ts),
        .hit_flags             (hit),
        .hit_clear             (clr),
        .scan_done             (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] slow;
        logic [8:0] never;
        logic [8:0] exp_ts;
        logic [8:0] exp_hit;
    } vec_t;

    vec_t tbl[10];
    int   n_pass = 0;
    int   n_total = 0;
    int   delay[9];
    int   run = 0;
    int   out_hi = 0;
    int   tick_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Pad i reads high once the charge drive has been high for delay[i] sampled cycles.
    task automatic tick;
        @(posedge clock);
        #1;
        tick_cnt++;
        if (cs_out === 1'b1) begin
            run++;
            out_hi++;
        end else begin
            run = 0;
        end
        for (int i = 0; i < 9; i++) cs_in[i] = (cs_out === 1'b1) && (run >= delay[i]);
    endtask

    task automatic set_pads(input logic [8:0] slow, input logic [8:0] never);
        for (int i = 0; i < 9; i++) delay[i] = never[i] ? NEVER : (slow[i] ? 40 : 5);
    endtask

    task automatic release_reset;
        @(negedge clock);
        reset    = 1'b0;
        tick_cnt = 0;
        run      = 0;
        out_hi   = 0;
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        clr   = 9'h000;
        cs_in = 9'h000;
        run   = 0;
        @(posedge clock);
        @(posedge clock);
        release_reset();
    endtask

    task automatic wait_done(input int bound, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (done !== 1'b1 && waited < bound);
        check("scan_done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_out(input logic lvl, input int bound, output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (cs_out !== lvl && waited < bound);
        check("out_level_seen", {31'd0, cs_out}, {31'd0, lvl});
    endtask

    logic [8:0] m_ts, m_hit, m_raw, cmask;
    logic [8:0] hist[$];
    int         w;
    logic       any_done, any_out;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{9'h000, 9'h000, 9'h000, 9'h000};
        tbl[1] = '{9'h000, 9'h000, 9'h000, 9'h000};
        tbl[2] = '{9'h014, 9'h001, 9'h000, 9'h000};
        tbl[3] = '{9'h010, 9'h001, 9'h000, 9'h000};
        tbl[4] = '{9'h014, 9'h001, 9'h011, 9'h011};
        tbl[5] = '{9'h010, 9'h001, 9'h011, 9'h011};
        tbl[6] = '{9'h014, 9'h001, 9'h011, 9'h011};
        tbl[7] = '{9'h000, 9'h000, 9'h011, 9'h011};
        tbl[8] = '{9'h000, 9'h000, 9'h011, 9'h011};
        tbl[9] = '{9'h000, 9'h000, 9'h000, 9'h011};

        reset  = 1'b1;
        enable = 1'b1;
        clr    = 9'h000;
        cs_in  = 9'h000;
        set_pads(tbl[0].slow, tbl[0].never);
        #12;
        check("rst_out", {31'd0, cs_out}, 32'd0);
        check("rst_ts", {23'd0, ts}, 32'd0);
        check("rst_hit", {23'd0, hit}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        release_reset();

        // Directed scan table
        for (int k = 0; k < 9; k++) tick();
        check("idle_out_low", {31'd0, cs_out}, 32'd0);
        tick();
        check("charge_start", {31'd0, cs_out}, 32'd1);
        for (int r = 0; r < 10; r++) begin
            wait_done(200, w);
            check("done_cycle", tick_cnt, SCAN * r + SCAN - 1);
            check("charge_len", out_hi, MAXC);
            check("tbl_ts", {23'd0, ts}, {23'd0, tbl[r].exp_ts});
            check("tbl_hit", {23'd0, hit}, {23'd0, tbl[r].exp_hit});
            out_hi = 0;
            if (r < 9) set_pads(tbl[r+1].slow, tbl[r+1].never);
            tick();
            check("done_pulse", {31'd0, done}, 32'd0);
        end

        // Set and clear on the same edge: set wins; later clears touch only their own bit
        set_pads(9'h010, 9'h001);
        do_reset();
        wait_done(200, w);
        wait_done(200, w);
        wait_out(1'b1, 200, w);
        wait_out(1'b0, 200, w);
        for (int k = 0; k < DISC - 1; k++) tick();
        clr = 9'h010;
        tick();
        clr = 9'h000;
        check("setclr_done", {31'd0, done}, 32'd1);
        check("setclr_ts", {23'd0, ts}, 32'h011);
        check("setclr_hit", {23'd0, hit}, 32'h011);
        tick();
        check("hit_held", {23'd0, hit}, 32'h011);
        clr = 9'h010;
        tick();
        clr = 9'h000;
        check("hit_clear4", {23'd0, hit}, 32'h001);
        clr = 9'h010;
        tick();
        clr = 9'h000;
        check("hit_clear_zero", {23'd0, hit}, 32'h001);

        // Enable drop mid-charge: aborts, holds touch/hit state, restarts after the interval
        wait_out(1'b1, 200, w);
        for (int k = 0; k < 29; k++) tick();
        enable = 1'b0;
        tick();
        check("abort_out", {31'd0, cs_out}, 32'd0);
        any_done = 1'b0;
        any_out  = 1'b0;
        for (int k = 0; k < 120; k++) begin
            tick();
            any_done |= done;
            any_out  |= cs_out;
        end
        check("abort_no_done", {31'd0, any_done}, 32'd0);
        check("abort_no_out", {31'd0, any_out}, 32'd0);
        check("abort_ts", {23'd0, ts}, 32'h011);
        check("abort_hit", {23'd0, hit}, 32'h001);
        enable = 1'b1;
        wait_out(1'b1, 50, w);
        check("restart_delay", w, SINT);
        wait_done(200, w);
        check("restart_done", w, MAXC + DISC);
        check("restart_ts", {23'd0, ts}, 32'h011);

        // Reset mid-discharge, then mid-charge: outputs drop without waiting for a clock
        wait_out(1'b1, 200, w);
        wait_out(1'b0, 200, w);
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        check("rstd_ts", {23'd0, ts}, 32'd0);
        check("rstd_hit", {23'd0, hit}, 32'd0);
        check("rstd_done", {31'd0, done}, 32'd0);
        release_reset();
        wait_out(1'b1, 50, w);
        check("rst_restart", w, SINT);
        for (int k = 0; k < 5; k++) tick();
        #2 reset = 1'b1;
        #1;
        check("rstc_out", {31'd0, cs_out}, 32'd0);

        // Randomized pad timing against a scan-level model
        m_ts  = 9'h000;
        m_hit = 9'h000;
        hist.delete();
        for (int i = 0; i < 9; i++) delay[i] = 5;
        release_reset();
        for (int s = 0; s < 40; s++) begin
            for (int i = 0; i < 9; i++) begin
                case ($urandom_range(0, 2))
                    0:       begin delay[i] = $urandom_range(1, 12);  m_raw[i] = 1'b0; end
                    1:       begin delay[i] = $urandom_range(28, 60); m_raw[i] = 1'b1; end
                    default: begin delay[i] = NEVER;                  m_raw[i] = 1'b1; end
                endcase
            end
            hist.push_back(m_raw);
            if (hist.size() > DEB) void'(hist.pop_front());
            for (int i = 0; i < 9; i++) begin
                logic flip;
                flip = (hist.size() == DEB);
                foreach (hist[j]) if (hist[j][i] == m_ts[i]) flip = 1'b0;
                if (flip) begin
                    if (!m_ts[i]) m_hit[i] = 1'b1;
                    m_ts[i] = ~m_ts[i];
                end
            end
            wait_done(200, w);
            check("rnd_ts", {23'd0, ts}, {23'd0, m_ts});
            check("rnd_hit", {23'd0, hit}, {23'd0, m_hit});
            if ($urandom_range(0, 2) == 0) begin
                cmask = 9'($urandom_range(0, 511));
                clr = cmask;
                tick();
                clr = 9'h000;
                m_hit = m_hit & ~cmask;
                check("rnd_clear", {23'd0, hit}, {23'd0, m_hit});
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
